// File: rtl/cpu4_regfile_sb.sv
// cpu4_regfile_sb: register file with per-register busy (scoreboard) bits.
// NRD combinational read ports, two write-back ports, one issue port, flush.
// Optional feature: define CPU4_RF_BYPASS_EN to forward same-cycle write-back
// data (and busy status) to matching read ports; undefined means reads show
// stored state only.
module cpu4_regfile_sb #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RFREG_NUM   = 32,
    parameter int unsigned RFIDX_WIDTH = 5,
    parameter int unsigned NRD         = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NRD*RFIDX_WIDTH-1:0]   rs_idx,
    output logic [NRD*XLEN-1:0]          rs_data,
    output logic [NRD-1:0]               rs_busy,
    input  logic                         wb0_wen,
    input  logic [RFIDX_WIDTH-1:0]       wb0_idx,
    input  logic [XLEN-1:0]              wb0_data,
    input  logic                         wb1_wen,
    input  logic [RFIDX_WIDTH-1:0]       wb1_idx,
    input  logic [XLEN-1:0]              wb1_data,
    input  logic                         iss_vld,
    input  logic [RFIDX_WIDTH-1:0]       iss_idx,
    input  logic                         flush,
    output logic [RFIDX_WIDTH:0]         busy_cnt
);

    localparam int unsigned CNT_W = RFIDX_WIDTH + 1;

    // An index names real storage only if it is nonzero and below RFREG_NUM.
    function automatic logic idx_ok(input logic [RFIDX_WIDTH-1:0] idx);
        return (idx != '0) && (32'(idx) < RFREG_NUM);
    endfunction

    logic [XLEN-1:0]      regs [RFREG_NUM];
    logic [RFREG_NUM-1:0] busy;
    logic [RFREG_NUM-1:0] busy_nxt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 wb0_hit;
    logic                 wb1_hit;
    logic                 iss_hit;

    assign wb0_hit = wb0_wen && idx_ok(wb0_idx);
    assign wb1_hit = wb1_wen && idx_ok(wb1_idx);
    // Flush drops a same-cycle issue.
    assign iss_hit = iss_vld && idx_ok(iss_idx) && !flush;

    // Register storage; port 1 wins on a same-index double write, x0 never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < RFREG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < RFREG_NUM; i++) begin
                if (wb1_hit && (32'(wb1_idx) == i)) begin
                    regs[i] <= wb1_data;
                end else if (wb0_hit && (32'(wb0_idx) == i)) begin
                    regs[i] <= wb0_data;
                end
            end
        end
    end

    // Next busy vector: flush clears all, else write-backs clear and issue sets last.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (wb0_hit) begin
                busy_nxt[wb0_idx] = 1'b0;
            end
            if (wb1_hit) begin
                busy_nxt[wb1_idx] = 1'b0;
            end
            if (iss_hit) begin
                busy_nxt[iss_idx] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    // Population count of the next busy vector, registered alongside it.
    always_comb begin
        cnt_nxt = '0;
        for (int unsigned i = 0; i < RFREG_NUM; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
        end
    end

    // Busy bits and their count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [RFIDX_WIDTH-1:0] rd_idx;
        logic [XLEN-1:0]        rd_data;
        logic                   rd_busy;

        assign rd_idx = rs_idx[k*RFIDX_WIDTH +: RFIDX_WIDTH];

        // Read port k: stored state, optionally overridden by same-cycle write-back.
        always_comb begin
            rd_data = '0;
            rd_busy = 1'b0;
            if (idx_ok(rd_idx)) begin
                rd_data = regs[rd_idx];
                rd_busy = busy[rd_idx];
`ifdef CPU4_RF_BYPASS_EN
                if (wb1_hit && (wb1_idx == rd_idx)) begin
                    rd_data = wb1_data;
                    rd_busy = iss_hit && (iss_idx == rd_idx);
                end else if (wb0_hit && (wb0_idx == rd_idx)) begin
                    rd_data = wb0_data;
                    rd_busy = iss_hit && (iss_idx == rd_idx);
                end
`endif
            end
        end

        assign rs_data[k*XLEN +: XLEN] = rd_data;
        assign rs_busy[k]              = rd_busy;
    end

endmodule

// File: tb/tb_cpu4_regfile_sb.sv
// Directed testbench for cpu4_regfile_sb (default parameters).
// Expected values follow CPU4_RF_BYPASS_EN if the bench is built with it.
module tb_cpu4_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  rs_idx;
    logic [63:0] rs_data;
    logic [1:0]  rs_busy;
    logic        wb0_wen;
    logic [4:0]  wb0_idx;
    logic [31:0] wb0_data;
    logic        wb1_wen;
    logic [4:0]  wb1_idx;
    logic [31:0] wb1_data;
    logic        iss_vld;
    logic [4:0]  iss_idx;
    logic        flush;
    logic [5:0]  busy_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    cpu4_regfile_sb dut (
        .clk      (clk),
        .rst      (rst),
        .rs_idx   (rs_idx),
        .rs_data  (rs_data),
        .rs_busy  (rs_busy),
        .wb0_wen  (wb0_wen),
        .wb0_idx  (wb0_idx),
        .wb0_data (wb0_data),
        .wb1_wen  (wb1_wen),
        .wb1_idx  (wb1_idx),
        .wb1_data (wb1_data),
        .iss_vld  (iss_vld),
        .iss_idx  (iss_idx),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wb0_wen = 1'b0; wb0_idx = '0; wb0_data = '0;
        wb1_wen = 1'b0; wb1_idx = '0; wb1_data = '0;
        iss_vld = 1'b0; iss_idx = '0; flush = 1'b0;
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] i1, input logic [4:0] i0);
        rs_idx = {i1, i0};
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rs_idx = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_cnt_async", 96'(busy_cnt), 96'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // All registers zero and idle after reset.
        for (int i = 0; i < 32; i++) begin
            rd(5'(31 - i), 5'(i));
            check($sformatf("rst_rd_x%0d", i), {30'd0, rs_busy, rs_data}, 96'd0);
        end
        check("rst_cnt", 96'(busy_cnt), 96'd0);

        // x0 ignores writes.
        wb0_wen = 1'b1; wb0_idx = 5'd0; wb0_data = 32'hDEADBEEF;
        tick(); idle();
        rd(5'd0, 5'd0);
        check("x0_zero", 96'(rs_data), 96'd0);

        // x5 write: old value before the edge (no bypass), new value after.
        wb0_wen = 1'b1; wb0_idx = 5'd5; wb0_data = 32'h12345678;
        rd(5'd0, 5'd5);
`ifdef CPU4_RF_BYPASS_EN
        check("x5_same_cycle", 96'(rs_data[31:0]), 96'h12345678);
`else
        check("x5_same_cycle", 96'(rs_data[31:0]), 96'h0);
`endif
        tick(); idle();
        rd(5'd0, 5'd5);
        check("x5_next_cycle", 96'(rs_data[31:0]), 96'h12345678);

        // Double write to x7: port 1 wins.
        wb0_wen = 1'b1; wb0_idx = 5'd7; wb0_data = 32'h1111;
        wb1_wen = 1'b1; wb1_idx = 5'd7; wb1_data = 32'h2222;
        tick(); idle();
        rd(5'd5, 5'd7);
        check("x7_port1_wins", 96'(rs_data), {32'd0, 32'h12345678, 32'h2222});

        // Issue x3, x4, x9 on successive cycles.
        iss_vld = 1'b1; iss_idx = 5'd3; tick();
        check("cnt_after_x3", 96'(busy_cnt), 96'd1);
        iss_idx = 5'd4; tick();
        check("cnt_after_x4", 96'(busy_cnt), 96'd2);
        iss_idx = 5'd9; tick();
        check("cnt_after_x9", 96'(busy_cnt), 96'd3);
        idle();
        rd(5'd4, 5'd3);
        check("busy_x3_x4", 96'(rs_busy), 96'b11);

        // Write-back x4 clears its busy bit.
        wb0_wen = 1'b1; wb0_idx = 5'd4; wb0_data = 32'h44;
        tick(); idle();
        rd(5'd4, 5'd9);
        check("cnt_after_wb_x4", 96'(busy_cnt), 96'd2);
        check("busy_x4_x9", {30'd0, rs_busy, rs_data}, {30'd0, 2'b01, 32'h44, 32'h0});

        // Issue and write-back on x3 together: stays busy, data written.
        iss_vld = 1'b1; iss_idx = 5'd3;
        wb1_wen = 1'b1; wb1_idx = 5'd3; wb1_data = 32'h33;
        tick(); idle();
        rd(5'd0, 5'd3);
        check("cnt_iss_wb_x3", 96'(busy_cnt), 96'd2);
        check("x3_busy_data", {63'd0, rs_busy[0], rs_data[31:0]}, {63'd0, 1'b1, 32'h33});

        // Third busy register, then flush with a dropped issue and a live write.
        iss_vld = 1'b1; iss_idx = 5'd12; tick();
        check("cnt_after_x12", 96'(busy_cnt), 96'd3);
        flush = 1'b1; iss_vld = 1'b1; iss_idx = 5'd6;
        wb0_wen = 1'b1; wb0_idx = 5'd8; wb0_data = 32'h88;
        tick(); idle();
        rd(5'd6, 5'd8);
        check("cnt_after_flush", 96'(busy_cnt), 96'd0);
        check("flush_x6_x8", {30'd0, rs_busy, rs_data}, {30'd0, 2'b00, 32'h0, 32'h88});

        // Write-back to an idle register must not underflow the count.
        wb0_wen = 1'b1; wb0_idx = 5'd20; wb0_data = 32'h20;
        tick(); idle();
        check("cnt_no_underflow", 96'(busy_cnt), 96'd0);

        // x10 read while written on wb0.
        wb0_wen = 1'b1; wb0_idx = 5'd10; wb0_data = 32'hA5A5A5A5;
        rd(5'd10, 5'd5);
`ifdef CPU4_RF_BYPASS_EN
        check("x10_same_cycle", {30'd0, rs_busy, rs_data}, {30'd0, 2'b00, 32'hA5A5A5A5, 32'h12345678});
`else
        check("x10_same_cycle", {30'd0, rs_busy, rs_data}, {30'd0, 2'b00, 32'h0, 32'h12345678});
`endif
        tick(); idle();
        rd(5'd10, 5'd5);
        check("x10_next_cycle", 96'(rs_data), {32'd0, 32'hA5A5A5A5, 32'h12345678});

        // Busy x10 and a write-back on it plus a fresh issue: busy shown only with issue.
        iss_vld = 1'b1; iss_idx = 5'd10; tick(); idle();
        wb1_wen = 1'b1; wb1_idx = 5'd10; wb1_data = 32'h5A5A5A5A;
        iss_vld = 1'b1; iss_idx = 5'd10;
        rd(5'd10, 5'd0);
`ifdef CPU4_RF_BYPASS_EN
        check("x10_byp_iss", {30'd0, rs_busy, rs_data}, {30'd0, 2'b10, 32'h5A5A5A5A, 32'h0});
`else
        check("x10_byp_iss", {30'd0, rs_busy, rs_data}, {30'd0, 2'b10, 32'hA5A5A5A5, 32'h0});
`endif
        tick(); idle();
        check("cnt_x10_reissue", 96'(busy_cnt), 96'd1);

        // Mid-operation reset: async clear, in-flight write and issue discarded.
        iss_vld = 1'b1; iss_idx = 5'd13;
        wb0_wen = 1'b1; wb0_idx = 5'd11; wb0_data = 32'hBB;
        #2 rst = 1'b1;
        rd(5'd10, 5'd5);
        check("midrst_async", {26'd0, busy_cnt, rs_busy, rs_data}, 96'd0);
        tick();
        idle();
        rst = 1'b0;
        rd(5'd13, 5'd11);
        check("midrst_after", {26'd0, busy_cnt, rs_busy, rs_data}, 96'd0);
        tick();
        check("midrst_cnt_hold", 96'(busy_cnt), 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu4_regfile_sb.md
CPU4_REGFILE_SB -- requirements
Module: cpu4_regfile_sb

Interface
REQ-001 Parameter XLEN, 32, data width of each register.
REQ-002 Parameter RFREG_NUM, 32, number of architectural registers, including x0.
REQ-003 Parameter RFIDX_WIDTH, 5, register index width; SHALL equal clog2(RFREG_NUM).
REQ-004 Parameter NRD, 2, number of read ports.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 rs_idx  input  NRD*RFIDX_WIDTH  packed read indices; port k uses bits [k*RFIDX_WIDTH +: RFIDX_WIDTH].
REQ-008 rs_data  output  NRD*XLEN  packed read data, one XLEN slice per port k.
REQ-009 rs_busy  output  NRD  per-port flag: the register read on that port has a pending producer.
REQ-010 wb0_wen / wb0_idx / wb0_data  input  1 / RFIDX_WIDTH / XLEN  write-back port 0.
REQ-011 wb1_wen / wb1_idx / wb1_data  input  1 / RFIDX_WIDTH / XLEN  write-back port 1.
REQ-012 iss_vld / iss_idx  input  1 / RFIDX_WIDTH  issue request; marks the destination register busy.
REQ-013 flush  input  1  clears all busy bits; register contents are untouched.
REQ-014 busy_cnt  output  RFIDX_WIDTH+1  registered count of registers whose busy bit is set.

Function
REQ-015 Each of registers 1..RFREG_NUM-1 SHALL hold XLEN bits and its busy bit.
REQ-016 Register x0 SHALL read as zero, SHALL ignore all writes, and SHALL never be busy.
REQ-017 Reads SHALL be combinational from the current state, with zero-cycle latency.
REQ-018 Any index at or above RFREG_NUM SHALL read as zero and not busy; writes and issues to such an index SHALL be ignored.
REQ-019 A write on wbN_wen=1 SHALL update register wbN_idx at the clock edge.
REQ-020 If both write ports target the same index in one cycle, port 1 SHALL win.
REQ-021 A write-back SHALL clear the busy bit of its register at the edge.
REQ-022 An issue (iss_vld=1) SHALL set the busy bit of iss_idx at the edge.
REQ-023 If an issue and a write-back target the same register in one cycle, the busy bit SHALL end up set, because the new producer wins; the data write still occurs.
REQ-024 flush SHALL clear all busy bits and has priority over a same-cycle issue, which is then dropped; same-cycle data writes still occur.
REQ-025 busy_cnt SHALL equal the popcount of the busy bits after each edge, with no overflow and no underflow.

Reset
REQ-026 While rst=1, all registers SHALL be 0x0, all busy bits SHALL be 0, and busy_cnt SHALL be 0, asynchronously and independent of clk.
REQ-027 After reset, rs_data SHALL read 0 and rs_busy SHALL read 0 on every port.
REQ-028 Reset asserted mid-operation SHALL discard any writes and issues in flight in that cycle.

Configuration
REQ-029 Macro CPU4_RF_BYPASS_EN selects write-to-read bypass.
REQ-030 With CPU4_RF_BYPASS_EN defined, a read port whose index matches an active wbN_idx SHALL return that cycle's wbN_data (port 1 first) and SHALL show rs_busy=0, unless a same-cycle issue targets that register.
REQ-031 Without CPU4_RF_BYPASS_EN, reads SHALL return only the stored state, and the written value SHALL appear one cycle after the write.

Verification
REQ-032 Reset, then read x0..x31 on all ports -> rs_data=0 and rs_busy=0 everywhere, busy_cnt=0.
REQ-033 Write x0=0xDEADBEEF, then read x0 -> 0x0; write x5=0x12345678 on port 0 -> next cycle rs_data for x5 = 0x12345678.
REQ-034 Same cycle: wb0 x7=0x1111 and wb1 x7=0x2222 -> x7 reads 0x2222.
REQ-035 Issue x3, x4, x9 on successive cycles -> busy_cnt reads 1, 2, 3; write-back x4 -> busy_cnt=2 and rs_busy for x4 = 0; issue plus write-back on x3 in one cycle -> x3 stays busy and busy_cnt=2.
REQ-036 Flush and issue x6 in one cycle with 3 registers busy -> busy_cnt=0 and x6 not busy.
REQ-037 With bypass enabled, wb0 x10=0xA5A5A5A5 while reading x10 -> same-cycle rs_data=0xA5A5A5A5 and rs_busy=0; with bypass disabled -> the old value that cycle and the new value the next cycle.
